onehot_encoder_pipe: RTL and testbench

ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

---
 rtl/onehot_encoder_pipe.sv | 114 +++++++++++
 tb/tb_onehot_encoder_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe
// Converts an N-bit one-hot code into its binary index behind a single
// valid/ready register stage. It flags illegal codes and keeps a
// saturating count of the illegal codes it has accepted.
//
// PRIORITY = 0 : strict one-hot. An all-zero code or a code with more than
//                one bit set gives out_bin = 0 and out_err = 1.
// PRIORITY = 1 : the lowest set bit wins. Only an all-zero code is an error.
//
// All out_* signals and err_count are driven directly from registers, so
// no combinational path runs from in_code to any output.
module onehot_encoder_pipe #(
    parameter int N        = 10,
    parameter int PRIORITY = 0,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_bin,
    output logic                   out_err,
    input  logic                   clr_count,
    output logic [CNT_W-1:0]       err_count
);

    localparam int W = $clog2(N);

    localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    logic           r_outValid;
    logic [W-1:0]   r_outBin;
    logic           r_outErr;
    logic [CNT_W-1:0] r_errCount;

    logic           w_inXfer;
    logic           w_anySet;
    logic           w_singleSet;
    logic [W-1:0]   w_lowIdx;
    logic [W-1:0]   w_decBin;
    logic           w_decErr;

    // The stage can take a word when it is empty, or when the word it holds leaves on this edge
    assign in_ready  = !r_outValid || out_ready;
    assign w_inXfer  = in_valid && in_ready;

    // Classify the code: is any bit set, and is exactly one bit set (x & (x-1) clears the lowest set bit)
    assign w_anySet    = (in_code != '0);
    assign w_singleSet = w_anySet && ((in_code & (in_code - ONE_N)) == '0);

    // Find the index of the lowest set bit; scanning downward lets the lowest bit write last and win
    always_comb begin
        w_lowIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_code[i]) begin
                w_lowIdx = W'(i);
            end
        end
    end

    // Choose the decode rule from PRIORITY; any error case forces the index to zero
    always_comb begin
        w_decBin = '0;
        w_decErr = 1'b1;
        if (PRIORITY != 0) begin
            if (w_anySet) begin
                w_decBin = w_lowIdx;
                w_decErr = 1'b0;
            end
        end else begin
            if (w_singleSet) begin
                w_decBin = w_lowIdx;
                w_decErr = 1'b0;
            end
        end
    end

    // Output stage: load on an input transfer, empty on an output-only transfer, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outBin   <= '0;
            r_outErr   <= 1'b0;
        end else if (w_inXfer) begin
            r_outValid <= 1'b1;
            r_outBin   <= w_decBin;
            r_outErr   <= w_decErr;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Error counter: a clear beats an increment; an increment stops at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= '0;
        end else if (clr_count) begin
            r_errCount <= '0;
        end else if (w_inXfer && w_decErr && (r_errCount != CNT_FULL)) begin
            r_errCount <= r_errCount + CNT_ONE;
        end
    end

    assign out_valid = r_outValid;
    assign out_bin   = r_outBin;
    assign out_err   = r_outErr;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe
// Directed test of onehot_encoder_pipe using three instances:
//   a : defaults (N=10, strict decoding, CNT_W=8)
//   p : PRIORITY=1
//   s : CNT_W=2, used to exercise counter saturation
// Inputs change 1 ns after a rising edge. Outputs are sampled at the same
// point, after the registers have updated.
module tb_onehot_encoder_pipe;

    logic clk;
    logic rst_n;

    // Signals for instance a
    logic       aInValid, aInReady, aOutValid, aOutReady, aOutErr, aClr;
    logic [9:0] aInCode;
    logic [3:0] aOutBin;
    logic [7:0] aErrCount;

    // Signals for instance p
    logic       pInValid, pInReady, pOutValid, pOutReady, pOutErr, pClr;
    logic [9:0] pInCode;
    logic [3:0] pOutBin;
    logic [7:0] pErrCount;

    // Signals for instance s
    logic       sInValid, sInReady, sOutValid, sOutReady, sOutErr, sClr;
    logic [9:0] sInCode;
    logic [3:0] sOutBin;
    logic [1:0] sErrCount;

    int checkCount;
    int errorCount;

    onehot_encoder_pipe u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aInValid), .in_ready(aInReady), .in_code(aInCode),
        .out_valid(aOutValid), .out_ready(aOutReady),
        .out_bin(aOutBin), .out_err(aOutErr),
        .clr_count(aClr), .err_count(aErrCount)
    );

    onehot_encoder_pipe #(.N(10), .PRIORITY(1), .CNT_W(8)) u_pri (
        .clk(clk), .rst_n(rst_n),
        .in_valid(pInValid), .in_ready(pInReady), .in_code(pInCode),
        .out_valid(pOutValid), .out_ready(pOutReady),
        .out_bin(pOutBin), .out_err(pOutErr),
        .clr_count(pClr), .err_count(pErrCount)
    );

    onehot_encoder_pipe #(.N(10), .PRIORITY(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sInValid), .in_ready(sInReady), .in_code(sInCode),
        .out_valid(sOutValid), .out_ready(sOutReady),
        .out_bin(sOutBin), .out_err(sOutErr),
        .clr_count(sClr), .err_count(sErrCount)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the two values differ
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one instance's inputs, then wait until 1 ns after the next rising edge
    task automatic applyStimulus(input int sel, input logic valid, input logic [9:0] code,
                                 input logic ready, input logic clr);
        case (sel)
            0: begin aInValid = valid; aInCode = code; aOutReady = ready; aClr = clr; end
            1: begin pInValid = valid; pInCode = code; pOutReady = ready; pClr = clr; end
            default: begin sInValid = valid; sInCode = code; sOutReady = ready; sClr = clr; end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] code;
        checkCount = 0;
        errorCount = 0;
        aInValid = 0; aInCode = '0; aOutReady = 1; aClr = 0;
        pInValid = 0; pInCode = '0; pOutReady = 1; pClr = 0;
        sInValid = 0; sInCode = '0; sOutReady = 1; sClr = 0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst out_valid", 64'(aOutValid), 64'd0);
        checkOutput("rst out_bin", 64'(aOutBin), 64'd0);
        checkOutput("rst out_err", 64'(aOutErr), 64'd0);
        checkOutput("rst err_count", 64'(aErrCount), 64'd0);
        checkOutput("rst in_ready", 64'(aInReady), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sweep every legal one-hot code in strict mode
        for (int k = 0; k < 10; k++) begin
            code = 10'd1 << k;
            applyStimulus(0, 1'b1, code, 1'b1, 1'b0);
            checkOutput($sformatf("sweep%0d valid", k), 64'(aOutValid), 64'd1);
            checkOutput($sformatf("sweep%0d bin", k), 64'(aOutBin), 64'(k));
            checkOutput($sformatf("sweep%0d err", k), 64'(aOutErr), 64'd0);
        end
        checkOutput("sweep err_count", 64'(aErrCount), 64'd0);

        // Illegal codes: no bits set, then two bits set
        applyStimulus(0, 1'b1, 10'b0000000000, 1'b1, 1'b0);
        checkOutput("zero bin", 64'(aOutBin), 64'd0);
        checkOutput("zero err", 64'(aOutErr), 64'd1);
        applyStimulus(0, 1'b1, 10'b0000100100, 1'b1, 1'b0);
        checkOutput("two-bit bin", 64'(aOutBin), 64'd0);
        checkOutput("two-bit err", 64'(aOutErr), 64'd1);
        checkOutput("illegal err_count", 64'(aErrCount), 64'd2);

        // No input transfer: the word drains and the illegal code on in_code is ignored
        applyStimulus(0, 1'b0, 10'b0000000000, 1'b1, 1'b0);
        checkOutput("drain valid", 64'(aOutValid), 64'd0);
        checkOutput("idle err_count", 64'(aErrCount), 64'd2);

        // Clear the counter
        applyStimulus(0, 1'b0, 10'b0, 1'b1, 1'b1);
        checkOutput("clr err_count", 64'(aErrCount), 64'd0);
        aClr = 1'b0;

        // Backpressure: hold out_bin=5 for three cycles while the next word waits
        applyStimulus(0, 1'b1, 10'd1 << 5, 1'b0, 1'b0);
        checkOutput("bp load bin", 64'(aOutBin), 64'd5);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1'b1, 10'd1 << 7, 1'b0, 1'b0);
            checkOutput($sformatf("bp%0d valid", c), 64'(aOutValid), 64'd1);
            checkOutput($sformatf("bp%0d bin", c), 64'(aOutBin), 64'd5);
            checkOutput($sformatf("bp%0d in_ready", c), 64'(aInReady), 64'd0);
        end
        aOutReady = 1'b1;
        #1;
        checkOutput("bp release in_ready", 64'(aInReady), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("bp next bin", 64'(aOutBin), 64'd7);
        checkOutput("bp next valid", 64'(aOutValid), 64'd1);
        applyStimulus(0, 1'b0, 10'b0, 1'b1, 1'b0);
        checkOutput("bp drain valid", 64'(aOutValid), 64'd0);

        // Priority mode: the lowest set bit wins, and only zero is an error
        applyStimulus(1, 1'b1, 10'b1000100100, 1'b1, 1'b0);
        checkOutput("pri multi bin", 64'(pOutBin), 64'd2);
        checkOutput("pri multi err", 64'(pOutErr), 64'd0);
        applyStimulus(1, 1'b1, 10'b1000000000, 1'b1, 1'b0);
        checkOutput("pri top bin", 64'(pOutBin), 64'd9);
        applyStimulus(1, 1'b1, 10'b0000000000, 1'b1, 1'b0);
        checkOutput("pri zero bin", 64'(pOutBin), 64'd0);
        checkOutput("pri zero err", 64'(pOutErr), 64'd1);
        checkOutput("pri err_count", 64'(pErrCount), 64'd1);
        applyStimulus(1, 1'b0, 10'b0, 1'b1, 1'b0);

        // Saturation with a 2-bit counter: 1,2,3,3,3
        for (int c = 0; c < 5; c++) begin
            applyStimulus(2, 1'b1, 10'b0000000011, 1'b1, 1'b0);
            checkOutput($sformatf("sat%0d count", c), 64'(sErrCount), 64'((c < 3) ? c + 1 : 3));
        end
        // A clear arriving with an illegal transfer wins
        applyStimulus(2, 1'b1, 10'b0000000000, 1'b1, 1'b1);
        checkOutput("sat clr+inc count", 64'(sErrCount), 64'd0);
        checkOutput("sat clr+inc err", 64'(sOutErr), 64'd1);
        applyStimulus(2, 1'b0, 10'b0, 1'b1, 1'b0);

        // Reset in the middle of operation, while a held word is stalled
        applyStimulus(0, 1'b1, 10'b0000000011, 1'b0, 1'b0);
        checkOutput("pre-rst valid", 64'(aOutValid), 64'd1);
        checkOutput("pre-rst err", 64'(aOutErr), 64'd1);
        checkOutput("pre-rst count", 64'(aErrCount), 64'd1);
        aInValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst valid", 64'(aOutValid), 64'd0);
        checkOutput("async rst bin", 64'(aOutBin), 64'd0);
        checkOutput("async rst err", 64'(aOutErr), 64'd0);
        checkOutput("async rst count", 64'(aErrCount), 64'd0);
        checkOutput("async rst in_ready", 64'(aInReady), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 10'd1 << 4, 1'b1, 1'b0);
        checkOutput("post-rst bin", 64'(aOutBin), 64'd4);
        checkOutput("post-rst valid", 64'(aOutValid), 64'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
